// File: rtl/saida_display_pkg.sv
// Shared definitions for the BCD display output path: FSM states and sizing helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package saida_display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    CONCLUI  = 2'd2
  } estado_t;

  // Decimal digits needed for any DATA_WIDTH-bit unsigned value: ceil(w*log10(2)).
  // log10(2) ~= 0.30103, kept in fixed point so this stays a constant function.
  function automatic int calc_int_digits(input int largura);
    return (largura * 30103 + 99999) / 100000;
  endfunction

  // The counter must reach DATA_WIDTH without wrapping.
  function automatic int calc_largura_contador(input int largura);
    return $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/passo_double_dabble.sv
// One double-dabble iteration: +3 on every BCD nibble >= 5, then shift {acc, desl} left by one.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module passo_double_dabble #(
  parameter int INT_DIGITS = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic [4*INT_DIGITS-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   desl,
  output logic [4*INT_DIGITS-1:0] acc_prox,
  output logic [DATA_WIDTH-1:0]   desl_prox
);

  logic [4*INT_DIGITS-1:0] ajustado;

  // Correct every nibble before the shift so each one stays a valid BCD digit after doubling
  always_comb begin
    ajustado = acc;
    for (int i = 0; i < INT_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        ajustado[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    {acc_prox, desl_prox} = {ajustado, desl} << 1;
  end

endmodule

// File: rtl/saida_display_bcd.sv
// Converts the OUT operand into DIGITS BCD digits (sign + magnitude, overflow flag) by double-dabble.
// Latency: strobe edge k -> pronto during the cycle after edge k+DATA_WIDTH; one result per DATA_WIDTH+1 cycles.
// Backpressure: none; a strobe while converting is held in a one-entry pending buffer (last strobe wins).
module saida_display_bcd
  import saida_display_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIGITS     = 4,
  parameter int SIGNED     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sinal_out,
  input  logic [DATA_WIDTH-1:0] entrada_modulo,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [4*DIGITS-1:0]   digitos,
  output logic                  negativo,
  output logic                  estouro
);

  localparam int INT_DIGITS = calc_int_digits(DATA_WIDTH);
  localparam int ACC_W      = 4 * INT_DIGITS;
  localparam int OUT_W      = 4 * DIGITS;
  localparam int EXT_W      = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int CNT_W      = calc_largura_contador(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DATA_WIDTH - 1);

  estado_t               estado;
  logic [CNT_W-1:0]      contador;
  logic [ACC_W-1:0]      acumulador;
  logic [DATA_WIDTH-1:0] deslocador;
  logic                  sinal_conv;
  logic [DATA_WIDTH-1:0] pendente;
  logic                  pendente_vld;

  logic [ACC_W-1:0]      acc_prox;
  logic [DATA_WIDTH-1:0] desl_prox;
  logic [EXT_W-1:0]      acc_ext;
  logic [EXT_W-1:0]      acc_alto;
  logic                  inicia;
  logic [DATA_WIDTH-1:0] operando;
  logic                  operando_neg;
  logic [DATA_WIDTH-1:0] operando_mag;

  passo_double_dabble #(
    .INT_DIGITS (INT_DIGITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_passo (
    .acc       (acumulador),
    .desl      (deslocador),
    .acc_prox  (acc_prox),
    .desl_prox (desl_prox)
  );

  // Pick the next operand (a fresh strobe beats the pending entry) and derive sign and magnitude
  always_comb begin
    inicia       = 1'b0;
    operando     = entrada_modulo;
    operando_neg = 1'b0;
    operando_mag = '0;
    if (estado == OCIOSO && sinal_out) begin
      inicia = 1'b1;
    end else if (estado == CONCLUI && (sinal_out || pendente_vld)) begin
      inicia = 1'b1;
      if (!sinal_out) begin
        operando = pendente;
      end
    end
    operando_neg = (SIGNED != 0) && operando[DATA_WIDTH-1];
    // Most negative value negates to itself, which read as unsigned is exactly 2^(DATA_WIDTH-1)
    operando_mag = operando_neg ? (~operando + DATA_WIDTH'(1)) : operando;
  end

  // Widen the final accumulator so the digit slice and overflow OR work for any DIGITS
  always_comb begin
    acc_ext  = EXT_W'(acc_prox);
    acc_alto = acc_ext >> OUT_W;
  end

  // FSM, conversion datapath, pending buffer and display registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      contador     <= '0;
      acumulador   <= '0;
      deslocador   <= '0;
      sinal_conv   <= 1'b0;
      pendente     <= '0;
      pendente_vld <= 1'b0;
      digitos      <= '0;
      negativo     <= 1'b0;
      estouro      <= 1'b0;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          ocupado <= 1'b0;
        end
        CONVERTE: begin
          if (sinal_out) begin
            pendente     <= entrada_modulo;
            pendente_vld <= 1'b1;
          end
          acumulador <= acc_prox;
          deslocador <= desl_prox;
          contador   <= contador + CNT_W'(1);
          // Display updates only with the final shift, never with partial results
          if (contador == ULTIMO) begin
            estado   <= CONCLUI;
            pronto   <= 1'b1;
            digitos  <= acc_ext[OUT_W-1:0];
            negativo <= sinal_conv && (acc_ext != '0);
            estouro  <= |acc_alto;
          end
        end
        CONCLUI: begin
          // Pending entry is either consumed now or superseded by a newer strobe
          estado       <= OCIOSO;
          ocupado      <= 1'b0;
          pendente_vld <= 1'b0;
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
      if (inicia) begin
        estado     <= CONVERTE;
        ocupado    <= 1'b1;
        contador   <= '0;
        acumulador <= '0;
        deslocador <= operando_mag;
        sinal_conv <= operando_neg;
      end
    end
  end

endmodule

// File: tb/tb_saida_display_bcd.sv
// Self-checking bench for saida_display_bcd: scoreboard of expected displays checked on every pronto.
// Latency: checks pronto timing relative to the strobe edge and between back-to-back results.
// Backpressure: exercises the pending buffer (last strobe wins) and reset during a conversion.
module tb_saida_display_bcd;

  localparam int DATA_WIDTH = 32;
  localparam int DIGITS     = 4;
  localparam int SIGNED     = 1;
  localparam int LAT        = DATA_WIDTH;

  typedef struct packed {
    logic [4*DIGITS-1:0] dig;
    logic                neg;
    logic                est;
  } esperado_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  sinal_out;
  logic [DATA_WIDTH-1:0] entrada_modulo;
  logic                  ocupado;
  logic                  pronto;
  logic [4*DIGITS-1:0]   digitos;
  logic                  negativo;
  logic                  estouro;

  esperado_t fila[$];
  esperado_t ultimo;
  int checks  = 0;
  int errors  = 0;
  int ciclo   = 0;
  int n_pronto = 0;

  saida_display_bcd #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIGITS     (DIGITS),
    .SIGNED     (SIGNED)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sinal_out      (sinal_out),
    .entrada_modulo (entrada_modulo),
    .ocupado        (ocupado),
    .pronto         (pronto),
    .digitos        (digitos),
    .negativo       (negativo),
    .estouro        (estouro)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  // Reference: decimal digits by repeated division of the magnitude
  function automatic esperado_t modelo(input logic [DATA_WIDTH-1:0] op);
    esperado_t       e;
    longint unsigned mag;
    logic            neg;
    neg = (SIGNED != 0) && op[DATA_WIDTH-1];
    mag = neg ? (64'd4294967296 - {32'd0, op}) : {32'd0, op};
    for (int i = 0; i < DIGITS; i++) begin
      e.dig[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    e.neg = neg;
    e.est = (mag != 0);
    return e;
  endfunction

  // Scoreboard: every pronto pops one expected display
  always @(negedge clock) begin
    esperado_t e;
    if (reset === 1'b0 && pronto === 1'b1) begin
      n_pronto = n_pronto + 1;
      checks   = checks + 1;
      if (fila.size() == 0) begin
        errors = errors + 1;
        $display("FAIL pronto_inesperado ciclo=%0d digitos=%h neg=%b est=%b", ciclo, digitos, negativo, estouro);
      end else begin
        e = fila.pop_front();
        if ({digitos, negativo, estouro} !== e) begin
          errors = errors + 1;
          $display("FAIL resultado got dig=%h neg=%b est=%b exp dig=%h neg=%b est=%b",
                   digitos, negativo, estouro, e.dig, e.neg, e.est);
        end
      end
    end
  end

  // One-cycle strobe; borda is the index of the clock edge that samples it
  task automatic strobe(input logic [DATA_WIDTH-1:0] op, output int borda);
    @(negedge clock);
    entrada_modulo = op;
    sinal_out      = 1'b1;
    borda          = ciclo + 1;
    @(negedge clock);
    sinal_out      = 1'b0;
  endtask

  task automatic wait_livre(input int limite);
    int n;
    n = 0;
    while (ocupado !== 1'b0 && n < limite) begin
      @(negedge clock);
      n++;
    end
    checks = checks + 1;
    if (ocupado !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL timeout_ocupado got=%b exp=0 after %0d cycles", ocupado, limite);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sinal_out = 1'b0;
    entrada_modulo = '0;
    #12;
    checks = checks + 1;
    if ({digitos, negativo, estouro, ocupado, pronto} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_saidas got dig=%h neg=%b est=%b ocu=%b pr=%b exp all 0",
               digitos, negativo, estouro, ocupado, pronto);
    end
    @(negedge clock);
    reset = 1'b0;
    ultimo = '0;
  endtask

  task automatic test_latencia();
    int k;
    int visto;
    @(negedge clock);
    checks = checks + 1;
    if (ocupado !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL ocupado_antes got=%b exp=0", ocupado);
    end
    fila.push_back(modelo(32'd1234));
    strobe(32'd1234, k);
    checks = checks + 1;
    if (ocupado !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL ocupado_k1 got=%b exp=1", ocupado);
    end
    visto = -1;
    for (int i = 0; i < 100 && visto < 0; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) visto = ciclo;
      else if (digitos !== ultimo.dig) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL display_parcial got=%h exp=%h", digitos, ultimo.dig);
      end
    end
    checks = checks + 1;
    if (visto != k + LAT) begin
      errors = errors + 1;
      $display("FAIL latencia_pronto got edge=%0d exp edge=%0d", visto, k + LAT);
    end
    @(negedge clock);
    checks = checks + 1;
    if (pronto !== 1'b0 || ocupado !== 1'b0 || digitos !== 16'h1234) begin
      errors = errors + 1;
      $display("FAIL pronto_pulso got pr=%b ocu=%b dig=%h exp pr=0 ocu=0 dig=1234", pronto, ocupado, digitos);
    end
    ultimo = modelo(32'd1234);
  endtask

  task automatic test_valores();
    logic [DATA_WIDTH-1:0] ops[7];
    int k;
    ops = '{32'hFFFFFFC8, 32'd12345, 32'h80000000, 32'd0, 32'd9999, 32'd10000, 32'h7FFFFFFF};
    foreach (ops[i]) begin
      fila.push_back(modelo(ops[i]));
      strobe(ops[i], k);
      repeat (10) @(negedge clock);
      checks = checks + 1;
      if ({digitos, negativo, estouro} !== ultimo) begin
        errors = errors + 1;
        $display("FAIL display_mantido op=%h got dig=%h neg=%b est=%b exp dig=%h neg=%b est=%b",
                 ops[i], digitos, negativo, estouro, ultimo.dig, ultimo.neg, ultimo.est);
      end
      wait_livre(100);
      ultimo = modelo(ops[i]);
    end
  endtask

  task automatic test_back_to_back();
    int k0, k1, k2;
    int t[2];
    int cnt;
    cnt = 0;
    t[0] = -1;
    t[1] = -1;
    fila.push_back(modelo(32'd7));
    fila.push_back(modelo(32'd8));
    strobe(32'd7, k0);
    repeat (3) @(negedge clock);
    strobe(32'd9, k1);
    repeat (3) @(negedge clock);
    strobe(32'd8, k2);
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) begin
        if (cnt < 2) t[cnt] = ciclo;
        cnt++;
      end
    end
    checks = checks + 1;
    if (cnt != 2) begin
      errors = errors + 1;
      $display("FAIL b2b_num_pronto got=%0d exp=2 (strobes at edges %0d %0d %0d)", cnt, k0, k1, k2);
    end
    checks = checks + 1;
    if (t[0] != k0 + LAT) begin
      errors = errors + 1;
      $display("FAIL b2b_primeiro got edge=%0d exp edge=%0d", t[0], k0 + LAT);
    end
    checks = checks + 1;
    if (t[1] != t[0] + LAT + 1) begin
      errors = errors + 1;
      $display("FAIL b2b_segundo got edge=%0d exp edge=%0d", t[1], t[0] + LAT + 1);
    end
    wait_livre(10);
    ultimo = modelo(32'd8);
  endtask

  task automatic test_reset_abort();
    int k;
    int n0;
    fila.push_back(modelo(32'd1234));
    strobe(32'd1234, k);
    wait_livre(100);
    strobe(32'd5678, k);
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if ({digitos, negativo, estouro, ocupado, pronto} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_abort got dig=%h neg=%b est=%b ocu=%b pr=%b exp all 0",
               digitos, negativo, estouro, ocupado, pronto);
    end
    n0 = n_pronto;
    @(negedge clock);
    reset = 1'b0;
    repeat (45) @(negedge clock);
    #1;
    checks = checks + 1;
    if (n_pronto != n0 || ocupado !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL abort_sem_pronto got prontos=%0d ocu=%b exp prontos=%0d ocu=0", n_pronto, ocupado, n0);
    end
    fila.push_back(modelo(32'd42));
    strobe(32'd42, k);
    wait_livre(100);
    checks = checks + 1;
    if (digitos !== 16'h0042 || negativo !== 1'b0 || estouro !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL apos_reset got dig=%h neg=%b est=%b exp dig=0042 neg=0 est=0", digitos, negativo, estouro);
    end
  endtask

  initial begin
    test_reset();
    test_latencia();
    test_valores();
    test_back_to_back();
    test_reset_abort();
    repeat (2) @(negedge clock);
    checks = checks + 1;
    if (fila.size() != 0) begin
      errors = errors + 1;
      $display("FAIL fila_pendente got=%0d exp=0 leftover expected results", fila.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
